svc_rv_ext_fp_wb: RTL and testbench

SVC_RV_EXT_FP_WB -- requirements
Module: svc_rv_ext_fp_wb

---
 rtl/svc_rv_ext_fp_wb_pkg.sv | 34 +++
 rtl/svc_rv_ext_fp_wb_if.sv | 48 ++++
 rtl/svc_rv_ext_fp_wb.sv | 133 +++++++++++++
 tb/tb_svc_rv_ext_fp_wb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_ext_fp_wb_pkg.sv
// FP writeback shared definitions: FSM states, CSR selects and the fcsr read mux.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package svc_rv_ext_fp_wb_pkg;

  // Writeback FSM: IDLE accepts issue, WAIT tracks a multi-cycle op, DRAIN discards a flushed one.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fpwb_state_e;

  // csr_sel encodings; 0 selects nothing and reads as zero.
  localparam logic [1:0] CSR_NONE   = 2'd0;
  localparam logic [1:0] CSR_FFLAGS = 2'd1;
  localparam logic [1:0] CSR_FRM    = 2'd2;
  localparam logic [1:0] CSR_FCSR   = 2'd3;

  // Read view of the fcsr fields for a given select.
  function automatic logic [31:0] fcsr_read(input logic [1:0] sel,
                                            input logic [2:0] frm,
                                            input logic [4:0] flags);
    logic [31:0] r;
    r = 32'd0;
    case (sel)
      CSR_FFLAGS: r = {27'd0, flags};
      CSR_FRM:    r = {29'd0, frm};
      CSR_FCSR:   r = {24'd0, frm, flags};
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/svc_rv_ext_fp_wb_if.sv
// Bundle of issue, FP-unit, flush, writeback and CSR signals around the FP writeback stage.
// Latency: n/a (wires only).
// Backpressure: stall is driven by the writeback stage back towards issue.
interface svc_rv_ext_fp_wb_if;
  // Issue side (ID/EX boundary)
  logic        ex_issue;
  logic        ex_mc;
  logic [4:0]  ex_rd;
  logic        ex_rd_fp;
  // FP execution unit
  logic        fp_result_valid;
  logic [31:0] fp_result;
  logic [4:0]  fp_fflags;
  logic        fp_busy;
  // Control
  logic        flush;
  logic        stall;
  // Writeback
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_fp;
  logic [31:0] wb_data;
  // CSR access
  logic        csr_we;
  logic [1:0]  csr_sel;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [2:0]  frm_csr;
  logic [4:0]  fflags;

  // Pipeline / test driver side
  modport master (
    output ex_issue, ex_mc, ex_rd, ex_rd_fp,
    output fp_result_valid, fp_result, fp_fflags, fp_busy,
    output flush, csr_we, csr_sel, csr_wdata,
    input  stall, wb_valid, wb_rd, wb_fp, wb_data,
    input  csr_rdata, frm_csr, fflags
  );

  // Writeback stage side
  modport slave (
    input  ex_issue, ex_mc, ex_rd, ex_rd_fp,
    input  fp_result_valid, fp_result, fp_fflags, fp_busy,
    input  flush, csr_we, csr_sel, csr_wdata,
    output stall, wb_valid, wb_rd, wb_fp, wb_data,
    output csr_rdata, frm_csr, fflags
  );
endinterface

// File: rtl/svc_rv_ext_fp_wb.sv
// FP writeback stage: registers FP results to the regfile strobe and owns the fflags/frm CSR fields.
// Latency: 1 cycle from result (single-cycle issue or multi-cycle completion) to wb_valid.
// Backpressure: stall held from multi-cycle issue through WAIT/DRAIN; drops the cycle wb_valid fires.
module svc_rv_ext_fp_wb
  import svc_rv_ext_fp_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  svc_rv_ext_fp_wb_if.slave bus
);

  fpwb_state_e state_q, state_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        pend_fp_q, pend_fp_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_fp_q, wb_fp_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  fflags_q, fflags_d;
  logic [2:0]  frm_q, frm_d;
  logic        stall_c;

  // FSM next state, stall and writeback/CSR next values.
  always_comb begin
    state_d    = state_q;
    pend_rd_d  = pend_rd_q;
    pend_fp_d  = pend_fp_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_fp_d    = wb_fp_q;
    wb_data_d  = wb_data_q;
    fflags_d   = fflags_q;
    frm_d      = frm_q;
    stall_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ex_issue) begin
          if (bus.ex_mc) begin
            stall_c   = 1'b1;
            pend_rd_d = bus.ex_rd;
            pend_fp_d = bus.ex_rd_fp;
            // A flush in the issue cycle still leaves the EX unit busy, so drain its result.
            state_d   = bus.flush ? DRAIN : WAIT;
          end else if (bus.fp_result_valid && !bus.flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = bus.ex_rd;
            wb_fp_d    = bus.ex_rd_fp;
            wb_data_d  = bus.fp_result;
            fflags_d   = fflags_q | bus.fp_fflags;
          end
        end
        // A lone fp_result_valid with no issue is stale and dropped.
      end
      WAIT: begin
        stall_c = 1'b1;
        if (bus.fp_result_valid) begin
          state_d = IDLE;
          if (!bus.flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = pend_rd_q;
            wb_fp_d    = pend_fp_q;
            wb_data_d  = bus.fp_result;
            fflags_d   = fflags_q | bus.fp_fflags;
          end
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall_c = 1'b1;
        if (bus.fp_result_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // CSR write is younger than any op completing this cycle, so it overrides accrual.
    if (bus.csr_we) begin
      case (bus.csr_sel)
        CSR_FFLAGS: fflags_d = bus.csr_wdata[4:0];
        CSR_FRM:    frm_d    = bus.csr_wdata[2:0];
        CSR_FCSR: begin
          fflags_d = bus.csr_wdata[4:0];
          frm_d    = bus.csr_wdata[7:5];
        end
        default: ;
      endcase
    end
  end

  // State, pending destination, writeback and CSR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_rd_q  <= 5'd0;
      pend_fp_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_fp_q    <= 1'b0;
      wb_data_q  <= 32'd0;
      fflags_q   <= 5'd0;
      frm_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_fp_q  <= pend_fp_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_fp_q    <= wb_fp_d;
      wb_data_q  <= wb_data_d;
      fflags_q   <= fflags_d;
      frm_q      <= frm_d;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_fp     = wb_fp_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.fflags    = fflags_q;
  assign bus.frm_csr   = frm_q;
  assign bus.csr_rdata = fcsr_read(bus.csr_sel, frm_q, fflags_q);

  // Issue is only legal in IDLE; the pipeline must honour stall.
  a_no_issue_when_busy: assert property (@(posedge clk) disable iff (rst)
    !(bus.ex_issue && (state_q != IDLE)));

endmodule

// File: tb/tb_svc_rv_ext_fp_wb.sv
// Directed bench for the FP writeback stage: vector table for single-cycle ops plus sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_svc_rv_ext_fp_wb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  svc_rv_ext_fp_wb_if ifc ();

  svc_rv_ext_fp_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    logic [4:0]  rd;
    logic        rd_fp;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic [4:0]  exp_fflags;
    logic [2:0]  exp_frm;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ifc.ex_issue        = 1'b0;
    ifc.ex_mc           = 1'b0;
    ifc.ex_rd           = 5'd0;
    ifc.ex_rd_fp        = 1'b0;
    ifc.fp_result_valid = 1'b0;
    ifc.fp_result       = 32'd0;
    ifc.fp_fflags       = 5'd0;
    ifc.fp_busy         = 1'b0;
    ifc.flush           = 1'b0;
    ifc.csr_we          = 1'b0;
    ifc.csr_sel         = 2'd0;
    ifc.csr_wdata       = 32'd0;
  endtask

  int stall_cnt;
  int wb_seen;

  initial begin
    // {result, flags, rd, rd_fp, csr_we, csr_sel, csr_wdata, expected fflags, expected frm}
    vecs[0] = '{32'h40400000, 5'b00001, 5'd3,  1'b1, 1'b0, 2'd0, 32'h00, 5'b00001, 3'b000};
    vecs[1] = '{32'h3f800000, 5'b00100, 5'd7,  1'b0, 1'b0, 2'd0, 32'h00, 5'b00101, 3'b000};
    vecs[2] = '{32'h11111111, 5'b10000, 5'd1,  1'b1, 1'b1, 2'd1, 32'h00, 5'b00000, 3'b000};
    vecs[3] = '{32'h22222222, 5'b00001, 5'd2,  1'b1, 1'b1, 2'd3, 32'hE5, 5'b00101, 3'b111};
    vecs[4] = '{32'h33333333, 5'b00010, 5'd4,  1'b0, 1'b1, 2'd2, 32'h02, 5'b00111, 3'b010};
    vecs[5] = '{32'hFFFFFFFF, 5'b00000, 5'd31, 1'b1, 1'b0, 2'd0, 32'h00, 5'b00111, 3'b010};

    clr_in();
    rst = 1'b1;
    tick();
    tick();
    // Reset state (rst still high)
    ifc.csr_sel = 2'd3;
    #1;
    chk("rst_wb_valid", {31'd0, ifc.wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, ifc.wb_rd}, 32'd0);
    chk("rst_wb_fp", {31'd0, ifc.wb_fp}, 32'd0);
    chk("rst_wb_data", ifc.wb_data, 32'd0);
    chk("rst_fflags", {27'd0, ifc.fflags}, 32'd0);
    chk("rst_frm", {29'd0, ifc.frm_csr}, 32'd0);
    chk("rst_stall", {31'd0, ifc.stall}, 32'd0);
    chk("rst_rdata", ifc.csr_rdata, 32'd0);
    rst = 1'b0;
    clr_in();
    tick();

    // Single-cycle op table
    for (int i = 0; i < 6; i++) begin
      clr_in();
      ifc.ex_issue        = 1'b1;
      ifc.fp_result_valid = 1'b1;
      ifc.fp_result       = vecs[i].res;
      ifc.fp_fflags       = vecs[i].flg;
      ifc.ex_rd           = vecs[i].rd;
      ifc.ex_rd_fp        = vecs[i].rd_fp;
      ifc.csr_we          = vecs[i].we;
      ifc.csr_sel         = vecs[i].sel;
      ifc.csr_wdata       = vecs[i].wdata;
      #1;
      chk("vec_issue_stall", {31'd0, ifc.stall}, 32'd0);
      tick();
      clr_in();
      #1;
      chk("vec_wb_valid", {31'd0, ifc.wb_valid}, 32'd1);
      chk("vec_wb_data", ifc.wb_data, vecs[i].res);
      chk("vec_wb_rd", {27'd0, ifc.wb_rd}, {27'd0, vecs[i].rd});
      chk("vec_wb_fp", {31'd0, ifc.wb_fp}, {31'd0, vecs[i].rd_fp});
      chk("vec_fflags", {27'd0, ifc.fflags}, {27'd0, vecs[i].exp_fflags});
      chk("vec_frm", {29'd0, ifc.frm_csr}, {29'd0, vecs[i].exp_frm});
      chk("vec_wb_stall", {31'd0, ifc.stall}, 32'd0);
      tick();
      chk("vec_pulse_low", {31'd0, ifc.wb_valid}, 32'd0);
      chk("vec_data_hold", ifc.wb_data, vecs[i].res);
    end

    // FDIV: rd=5, result 10 cycles after issue with DZ
    rst = 1'b1;
    clr_in();
    tick();
    rst = 1'b0;
    stall_cnt = 0;
    wb_seen = 0;
    ifc.ex_issue = 1'b1;
    ifc.ex_mc    = 1'b1;
    ifc.ex_rd    = 5'd5;
    ifc.ex_rd_fp = 1'b1;
    #1;
    if (ifc.stall) stall_cnt++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      clr_in();
      ifc.fp_busy = 1'b1;
      if (k == 10) begin
        ifc.fp_result_valid = 1'b1;
        ifc.fp_result       = 32'h3f000000;
        ifc.fp_fflags       = 5'b01000;
      end
      #1;
      if (ifc.stall) stall_cnt++;
      if (ifc.wb_valid) wb_seen++;
    end
    chk("div_stall_cycles", stall_cnt, 32'd11);
    chk("div_no_early_wb", wb_seen, 32'd0);
    tick();
    clr_in();
    #1;
    chk("div_wb_valid", {31'd0, ifc.wb_valid}, 32'd1);
    chk("div_wb_rd", {27'd0, ifc.wb_rd}, 32'd5);
    chk("div_wb_fp", {31'd0, ifc.wb_fp}, 32'd1);
    chk("div_wb_data", ifc.wb_data, 32'h3f000000);
    chk("div_fflags", {27'd0, ifc.fflags}, 32'b01000);
    chk("div_stall_wb", {31'd0, ifc.stall}, 32'd0);

    // FSQRT flushed 3 cycles after issue, result at cycle 6
    tick();
    clr_in();
    wb_seen = 0;
    ifc.ex_issue = 1'b1;
    ifc.ex_mc    = 1'b1;
    ifc.ex_rd    = 5'd9;
    #1;
    chk("sqrt_issue_stall", {31'd0, ifc.stall}, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      clr_in();
      if (k == 3) ifc.flush = 1'b1;
      if (k == 6) begin
        ifc.fp_result_valid = 1'b1;
        ifc.fp_result       = 32'hCAFEF00D;
        ifc.fp_fflags       = 5'b11111;
      end
      #1;
      chk("sqrt_stall_held", {31'd0, ifc.stall}, 32'd1);
      if (ifc.wb_valid) wb_seen++;
    end
    tick();
    clr_in();
    #1;
    if (ifc.wb_valid) wb_seen++;
    chk("sqrt_no_wb", wb_seen, 32'd0);
    chk("sqrt_stall_drop", {31'd0, ifc.stall}, 32'd0);
    chk("sqrt_fflags_kept", {27'd0, ifc.fflags}, 32'b01000);
    chk("sqrt_data_kept", ifc.wb_data, 32'h3f000000);
    chk("sqrt_rd_kept", {27'd0, ifc.wb_rd}, 32'd5);

    // Flush in IDLE kills a single-cycle op's writeback
    ifc.ex_issue        = 1'b1;
    ifc.fp_result_valid = 1'b1;
    ifc.fp_result       = 32'h12345678;
    ifc.fp_fflags       = 5'b00001;
    ifc.flush           = 1'b1;
    tick();
    clr_in();
    #1;
    chk("iflush_no_wb", {31'd0, ifc.wb_valid}, 32'd0);
    chk("iflush_data", ifc.wb_data, 32'h3f000000);
    chk("iflush_fflags", {27'd0, ifc.fflags}, 32'b01000);

    // Stray result in IDLE ignored
    ifc.fp_result_valid = 1'b1;
    ifc.fp_result       = 32'hDEADBEEF;
    ifc.fp_fflags       = 5'b10000;
    tick();
    clr_in();
    #1;
    chk("stray_no_wb", {31'd0, ifc.wb_valid}, 32'd0);
    chk("stray_fflags", {27'd0, ifc.fflags}, 32'b01000);

    // Reset during WAIT
    ifc.ex_issue = 1'b1;
    ifc.ex_mc    = 1'b1;
    ifc.ex_rd    = 5'd12;
    tick();
    clr_in();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_stall", {31'd0, ifc.stall}, 32'd0);
    chk("rstw_wb_valid", {31'd0, ifc.wb_valid}, 32'd0);
    chk("rstw_fflags", {27'd0, ifc.fflags}, 32'd0);
    chk("rstw_wb_data", ifc.wb_data, 32'd0);
    tick();

    // Back-to-back single-cycle ops, NX then NV
    ifc.ex_issue        = 1'b1;
    ifc.fp_result_valid = 1'b1;
    ifc.fp_result       = 32'hAAAA0001;
    ifc.fp_fflags       = 5'b00001;
    ifc.ex_rd           = 5'd10;
    ifc.ex_rd_fp        = 1'b1;
    tick();
    ifc.fp_result = 32'hBBBB0002;
    ifc.fp_fflags = 5'b10000;
    ifc.ex_rd     = 5'd11;
    ifc.ex_rd_fp  = 1'b0;
    #1;
    chk("b2b_wb1", {31'd0, ifc.wb_valid}, 32'd1);
    chk("b2b_data1", ifc.wb_data, 32'hAAAA0001);
    chk("b2b_stall", {31'd0, ifc.stall}, 32'd0);
    tick();
    clr_in();
    #1;
    chk("b2b_wb2", {31'd0, ifc.wb_valid}, 32'd1);
    chk("b2b_data2", ifc.wb_data, 32'hBBBB0002);
    chk("b2b_rd2", {27'd0, ifc.wb_rd}, 32'd11);
    chk("b2b_fflags", {27'd0, ifc.fflags}, 32'b10001);

    // CSR write of fcsr then read-back through every select
    ifc.csr_we    = 1'b1;
    ifc.csr_sel   = 2'd3;
    ifc.csr_wdata = 32'hFFFFFFE5;
    tick();
    clr_in();
    ifc.csr_sel = 2'd2;
    #1;
    chk("csr_rd_frm", ifc.csr_rdata, 32'h7);
    ifc.csr_sel = 2'd1;
    #1;
    chk("csr_rd_fflags", ifc.csr_rdata, 32'h5);
    ifc.csr_sel = 2'd3;
    #1;
    chk("csr_rd_fcsr", ifc.csr_rdata, 32'hE5);
    ifc.csr_sel = 2'd0;
    #1;
    chk("csr_rd_none", ifc.csr_rdata, 32'h0);
    // frm-only write leaves fflags alone
    ifc.csr_we    = 1'b1;
    ifc.csr_sel   = 2'd2;
    ifc.csr_wdata = 32'h000000F9;
    tick();
    clr_in();
    #1;
    chk("csr_frm_only", {29'd0, ifc.frm_csr}, 32'd1);
    chk("csr_frm_flags_kept", {27'd0, ifc.fflags}, 32'b00101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
